spram_arb: RTL and testbench
============================

SPRAM_ARB -- requirements
Module: spram_arb

Interface
REQ-001 SHALL have parameter AW, default 14, SPRAM word-address width.
REQ-002 SHALL have parameter DW, default 32, data width; the mask width is DW/8.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports a_addr/b_addr  input  AW  requester A/B word address.
REQ-006 SHALL have ports a_wdata/b_wdata  input  DW  requester A/B write data.
REQ-007 SHALL have ports a_wmsk/b_wmsk  input  DW/8  requester A/B byte-write mask.
REQ-008 SHALL have ports a_we/b_we  input  1  requester A/B write (1) or read (0).
REQ-009 SHALL have ports a_req/b_req  input  1  requester A/B access request, level, held until ack.
REQ-010 SHALL have ports a_ack/b_ack  output  1  requester A/B access complete, single-cycle pulse.
REQ-011 SHALL have ports a_rdata/b_rdata  output  DW  requester A/B read data, valid only with ack.
REQ-012 SHALL have ports m_addr/m_wdata/m_wmsk/m_we  output  AW/DW/DW/8/1  SPRAM-side command.
REQ-013 SHALL have port m_rdata  input  DW  SPRAM read data, one cycle after the address.
REQ-014 SHALL have port gnt  output  2  one-hot grant of the current cycle (bit0=A, bit1=B).

Function
REQ-015 SHALL grant at most one requester per cycle; a requester is eligible when its req=1 and its ack is not asserted in that cycle.
REQ-016 SHALL drive m_* combinationally from the granted requester in the grant cycle; no grant -> m_we=0 and m_wmsk=0, with m_addr/m_wdata unchanged.
REQ-017 SHALL register the grant; the matching ack SHALL assert exactly one cycle after the grant (latency 1), for reads and writes alike.
REQ-018 SHALL drive x_rdata = m_rdata while x_ack=1, else 0 (combinational, no extra latency).
REQ-019 SHALL set m_we = x_we & grant and m_wmsk = x_wmsk when granted; a read SHALL never write.
REQ-020 SHALL let the other requester be granted in a requester's ack cycle, giving back-to-back memory use: A,B,A,B at one access per cycle.
REQ-021 SHALL let a requester that keeps req=1 through its ack cycle issue a new access, eligible from the cycle after the ack.
REQ-022 SHALL apply round-robin arbitration (see REQ-027) with a last-grant pointer; when both are eligible, the requester not granted last wins; the pointer SHALL update only on a grant.
REQ-023 SHALL grant a single eligible requester immediately regardless of the pointer.
REQ-024 SHALL ignore address, data, mask and we changes on an ungranted requester; they take effect only at grant.
REQ-025 SHALL keep its state limited to the pointer and the two ack registers; there is no other FSM.

Reset
REQ-026 SHALL, on rst_n=0 (asynchronous, including mid-access), clear a_ack, b_ack, the pointer (=A last, so B wins first contention), and gnt; m_we=0, m_wmsk=0, m_addr=0, m_wdata=0; an access granted in the reset cycle is dropped and never acked; outputs are valid from the first rising edge after release.

Configuration
REQ-027 SHALL implement round-robin only when SPRAM_ARB_RR_EN is defined; without the macro, A SHALL have fixed priority over B and the pointer logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 SHALL cover: A read, addr 0x0010, m_rdata=0xDEADBEEF next cycle -> a_ack 1 cycle after grant, a_rdata=0xDEADBEEF, b_ack=0.
REQ-029 SHALL cover: A and B request together from reset with RR -> B granted in cycle 0, A in cycle 1; acks in cycles 1 and 2; gnt=10 then 01.
REQ-030 SHALL cover: both held continuously for 8 cycles with RR -> gnt alternates, exactly 4 grants each; without macro -> A gets 4 grants, B 4 (A blocked in its ack cycles), never B twice in a row.
REQ-031 SHALL cover: B write, wmsk=0b0011, wdata=0x12345678, addr 0x3FFF -> m_we=1, m_wmsk=0011, m_addr=0x3FFF in grant cycle only; b_ack next cycle; b_rdata=0 outside ack.
REQ-032 SHALL cover: rst_n low in the cycle after A's grant -> a_ack never asserts, and the first grant after release follows REQ-026.

Source files
------------

// File: rtl/spram_arb.sv
// spram_arb: arbitrates two requesters (A, B) onto one single-port RAM.
// Each granted access is acknowledged exactly one cycle after its grant.
// The RAM returns read data on m_rdata one cycle after the address.
// A requester is served once per request; the other side may use the RAM in that ack cycle.
// Optional feature macro: SPRAM_ARB_RR_EN. When defined, contention is resolved
// round-robin. When undefined (the default), A has fixed priority over B.
`timescale 1ns/1ps
module spram_arb #(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_wdata,
    input  logic [DW/8-1:0] a_wmsk,
    input  logic            a_we,
    input  logic            a_req,
    output logic            a_ack,
    output logic [DW-1:0]   a_rdata,
    input  logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_wdata,
    input  logic [DW/8-1:0] b_wmsk,
    input  logic            b_we,
    input  logic            b_req,
    output logic            b_ack,
    output logic [DW-1:0]   b_rdata,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_wmsk,
    output logic            m_we,
    input  logic [DW-1:0]   m_rdata,
    output logic [1:0]      gnt
);

    // Arbitration state is the two ack flops plus the optional pointer.
    // run_reg only qualifies grants after reset release.
    // The hold registers keep m_addr/m_wdata stable across idle cycles.
    logic          a_ack_reg;
    logic          b_ack_reg;
    logic          run_reg;
    logic          a_elig;
    logic          b_elig;
    logic [AW-1:0] addr_hold_reg;
    logic [DW-1:0] wdata_hold_reg;

    // A requester sitting in its ack cycle cannot be granted again.
    // This lets the other side take the RAM in that cycle.
    assign a_elig = a_req & ~a_ack_reg;
    assign b_elig = b_req & ~b_ack_reg;

`ifdef SPRAM_ARB_RR_EN
    logic last_b_reg;

    // Last-served pointer; it moves only on an actual grant.
    // It resets to "A served last", so B wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b_reg <= 1'b0;
        end else if (gnt != 2'b00) begin
            last_b_reg <= gnt[1];
        end
    end
`endif

    // Choose this cycle's single winner among the eligible requesters.
    always_comb begin
        gnt = 2'b00;
        if (run_reg) begin
            if (a_elig && b_elig) begin
`ifdef SPRAM_ARB_RR_EN
                gnt = last_b_reg ? 2'b01 : 2'b10;
`else
                gnt = 2'b01;
`endif
            end else if (a_elig) begin
                gnt = 2'b01;
            end else if (b_elig) begin
                gnt = 2'b10;
            end
        end
    end

    // Route the winner's command to the RAM.
    // An idle cycle never writes and keeps the last address and data.
    always_comb begin
        m_addr  = addr_hold_reg;
        m_wdata = wdata_hold_reg;
        m_we    = 1'b0;
        m_wmsk  = '0;
        if (gnt[0]) begin
            m_addr  = a_addr;
            m_wdata = a_wdata;
            m_we    = a_we;
            m_wmsk  = a_wmsk;
        end else if (gnt[1]) begin
            m_addr  = b_addr;
            m_wdata = b_wdata;
            m_we    = b_we;
            m_wmsk  = b_wmsk;
        end
    end

    // Register the grant into the acks and capture the issued command for idle cycles.
    // A grant made while reset falls is lost because the acks clear asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg        <= 1'b0;
            a_ack_reg      <= 1'b0;
            b_ack_reg      <= 1'b0;
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
        end else begin
            run_reg   <= 1'b1;
            a_ack_reg <= gnt[0];
            b_ack_reg <= gnt[1];
            if (gnt != 2'b00) begin
                addr_hold_reg  <= m_addr;
                wdata_hold_reg <= m_wdata;
            end
        end
    end

    assign a_ack   = a_ack_reg;
    assign b_ack   = b_ack_reg;
    assign a_rdata = a_ack_reg ? m_rdata : '0;
    assign b_rdata = b_ack_reg ? m_rdata : '0;

endmodule

// File: tb/tb_spram_arb.sv
// tb_spram_arb: directed scenarios plus a randomized run checked against a transaction-level model.
// The RAM itself is emulated here: it writes with the byte mask and returns read data one cycle later.
`timescale 1ns/1ps
module tb_spram_arb;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int MW = DW / 8;
`ifdef SPRAM_ARB_RR_EN
    localparam logic [1:0] FIRST = 2'b10;
`else
    localparam logic [1:0] FIRST = 2'b01;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0, m_addr;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0, m_wdata, m_rdata;
    logic [MW-1:0] a_wmsk = '0, b_wmsk = '0, m_wmsk;
    logic          a_we = 1'b0, b_we = 1'b0, m_we;
    logic          a_req = 1'b0, b_req = 1'b0;
    logic          a_ack, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [1:0]    gnt;
    int            total = 0;
    int            bad = 0;

    spram_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_wmsk(a_wmsk), .a_we(a_we), .a_req(a_req),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_wmsk(b_wmsk), .b_we(b_we), .b_req(b_req),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wmsk(m_wmsk), .m_we(m_we), .m_rdata(m_rdata),
        .gnt(gnt)
    );

    always #5 clk = ~clk;

    // RAM emulator: masked byte write, registered read of the old contents.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] emu_w;
    always @(posedge clk) begin
        emu_w = mem[m_addr];
        for (int i = 0; i < MW; i++) if (m_wmsk[i]) emu_w[8*i +: 8] = m_wdata[8*i +: 8];
        if (m_we) mem[m_addr] <= emu_w;
        m_rdata <= mem[m_addr];
    end

    task automatic cyc(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask

    task automatic do_reset();
        a_req = 1'b0; b_req = 1'b0; rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
        a_wmsk = '1; b_wmsk = '1; a_addr = 14'h5; b_addr = 14'h6; a_wdata = 32'h1111; b_wdata = 32'h2222;
        cyc(); smp();
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b want=00", gnt); end
        total++; if (m_we !== 1'b0) begin bad++; $display("FAIL reset_m_we got=%b want=0", m_we); end
        total++; if (m_wmsk !== 4'h0) begin bad++; $display("FAIL reset_m_wmsk got=%h want=0", m_wmsk); end
        total++; if (m_addr !== 14'h0) begin bad++; $display("FAIL reset_m_addr got=%h want=0", m_addr); end
        total++; if (m_wdata !== 32'h0) begin bad++; $display("FAIL reset_m_wdata got=%h want=0", m_wdata); end
        total++; if ({a_ack, b_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks got=%b want=00", {a_ack, b_ack}); end
        a_req = 1'b0; b_req = 1'b0;
        cyc(); rst_n = 1'b1;
        cyc();
        $display("test_reset done");
    endtask

    task automatic test_a_read();
        a_req = 1'b1; a_we = 1'b1; a_addr = 14'h0010; a_wdata = 32'hDEADBEEF; a_wmsk = 4'hF;
        smp();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL aw_gnt got=%b want=01", gnt); end
        total++; if ({m_we, m_wmsk, m_addr} !== {1'b1, 4'hF, 14'h0010}) begin bad++; $display("FAIL aw_cmd got=%b/%h/%h want=1/f/0010", m_we, m_wmsk, m_addr); end
        cyc(); smp();
        total++; if ({a_ack, gnt} !== 3'b100) begin bad++; $display("FAIL aw_ack got=%b/%b want=1/00", a_ack, gnt); end
        cyc(); a_we = 1'b0;
        smp();
        total++; if ({gnt, m_we, a_ack} !== 4'b0100) begin bad++; $display("FAIL ar_grant got=%b/%b/%b want=01/0/0", gnt, m_we, a_ack); end
        cyc(); smp();
        total++; if (a_ack !== 1'b1) begin bad++; $display("FAIL ar_ack got=%b want=1", a_ack); end
        total++; if (a_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ar_rdata got=%h want=deadbeef", a_rdata); end
        total++; if ({b_ack, b_rdata} !== 33'h0) begin bad++; $display("FAIL ar_b_quiet got=%b/%h want=0/0", b_ack, b_rdata); end
        cyc(); a_req = 1'b0;
        smp();
        total++; if ({a_ack, a_rdata, gnt} !== 35'h0) begin bad++; $display("FAIL ar_after got=%b/%h/%b want=0/0/00", a_ack, a_rdata, gnt); end
        cyc();
        $display("test_a_read done");
    endtask

    task automatic test_b_write();
        b_req = 1'b1; b_we = 1'b1; b_addr = 14'h3FFF; b_wdata = 32'hFFFFFFFF; b_wmsk = 4'hF;
        smp();
        total++; if ({gnt, m_we} !== 3'b101) begin bad++; $display("FAIL bw0_grant got=%b/%b want=10/1", gnt, m_we); end
        cyc(); b_wdata = 32'h12345678; b_wmsk = 4'b0011;
        smp();
        total++; if ({b_ack, gnt, m_we, m_wmsk} !== 8'b1_00_0_0000) begin bad++; $display("FAIL bw0_ack got=%b/%b/%b/%h want=1/00/0/0", b_ack, gnt, m_we, m_wmsk); end
        cyc(); smp();
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL bw_gnt got=%b want=10", gnt); end
        total++; if ({m_we, m_wmsk, m_addr, m_wdata} !== {1'b1, 4'b0011, 14'h3FFF, 32'h12345678}) begin bad++; $display("FAIL bw_cmd got=%b/%h/%h/%h want=1/3/3fff/12345678", m_we, m_wmsk, m_addr, m_wdata); end
        total++; if (b_rdata !== 32'h0) begin bad++; $display("FAIL bw_rdata_idle got=%h want=0", b_rdata); end
        cyc(); b_we = 1'b0;
        smp();
        total++; if ({b_ack, m_we, m_wmsk} !== 6'b1_0_0000) begin bad++; $display("FAIL bw_ack got=%b/%b/%h want=1/0/0", b_ack, m_we, m_wmsk); end
        total++; if (m_addr !== 14'h3FFF) begin bad++; $display("FAIL bw_hold_addr got=%h want=3fff", m_addr); end
        cyc(); smp();
        total++; if ({gnt, m_we} !== 3'b100) begin bad++; $display("FAIL br_grant got=%b/%b want=10/0", gnt, m_we); end
        cyc(); smp();
        total++; if ({b_ack, b_rdata} !== {1'b1, 32'hFFFF5678}) begin bad++; $display("FAIL br_rdata got=%b/%h want=1/ffff5678", b_ack, b_rdata); end
        cyc(); b_req = 1'b0;
        smp();
        total++; if ({b_ack, b_rdata} !== 33'h0) begin bad++; $display("FAIL br_after got=%b/%h want=0/0", b_ack, b_rdata); end
        cyc();
        $display("test_b_write done");
    endtask

    task automatic test_contention();
        logic [1:0] f = FIRST;
        logic [1:0] s = ~FIRST;
        do_reset();
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0; a_addr = 14'h1; b_addr = 14'h2;
        smp();
        total++; if ({gnt, a_ack, b_ack} !== {f, 2'b00}) begin bad++; $display("FAIL cont_c0 got=%b/%b%b want=%b/00", gnt, a_ack, b_ack, f); end
        cyc(); smp();
        total++; if ({gnt, a_ack, b_ack} !== {s, f[0], f[1]}) begin bad++; $display("FAIL cont_c1 got=%b/%b%b want=%b/%b%b", gnt, a_ack, b_ack, s, f[0], f[1]); end
        cyc(); if (f[1]) b_req = 1'b0; else a_req = 1'b0;
        smp();
        total++; if ({gnt, a_ack, b_ack} !== {2'b00, s[0], s[1]}) begin bad++; $display("FAIL cont_c2 got=%b/%b%b want=00/%b%b", gnt, a_ack, b_ack, s[0], s[1]); end
        cyc(); a_req = 1'b0; b_req = 1'b0;
        cyc();
        $display("test_contention done");
    endtask

    task automatic test_alternate();
        logic [1:0] f = FIRST;
        logic [1:0] prev = 2'b00;
        logic [1:0] expg;
        int na = 0;
        int nb = 0;
        do_reset();
        a_req = 1'b1; b_req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            smp();
            expg = (c % 2 == 0) ? f : ~f;
            total++; if (gnt !== expg) begin bad++; $display("FAIL alt_gnt c=%0d got=%b want=%b", c, gnt, expg); end
            total++; if (gnt == 2'b10 && prev == 2'b10) begin bad++; $display("FAIL alt_b_twice c=%0d got=10 want=not 10", c); end
            if (gnt == 2'b01) na++;
            if (gnt == 2'b10) nb++;
            prev = gnt;
            cyc();
        end
        if (f[0]) a_req = 1'b0; else b_req = 1'b0;
        smp();
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL alt_tail got=%b want=00", gnt); end
        total++; if (na != 4 || nb != 4) begin bad++; $display("FAIL alt_counts got=%0d/%0d want=4/4", na, nb); end
        cyc(); a_req = 1'b0; b_req = 1'b0;
        cyc();
        $display("test_alternate done a=%0d b=%0d", na, nb);
    endtask

    task automatic test_reset_mid();
        logic [1:0] f = FIRST;
        logic [1:0] s = ~FIRST;
        a_req = 1'b1; a_we = 1'b0; a_addr = 14'h22;
        smp();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rm_grant got=%b want=01", gnt); end
        cyc(); rst_n = 1'b0; b_req = 1'b1;
        smp();
        total++; if ({a_ack, gnt, m_we, m_addr} !== 18'h0) begin bad++; $display("FAIL rm_in_reset got=%b/%b/%b/%h want=0/00/0/0", a_ack, gnt, m_we, m_addr); end
        cyc(); rst_n = 1'b1; a_req = 1'b0; b_req = 1'b0;
        smp();
        total++; if (a_ack !== 1'b0) begin bad++; $display("FAIL rm_release_ack got=%b want=0", a_ack); end
        cyc(); a_req = 1'b1; b_req = 1'b1;
        smp();
        total++; if ({gnt, a_ack} !== {f, 1'b0}) begin bad++; $display("FAIL rm_first got=%b/%b want=%b/0", gnt, a_ack, f); end
        cyc(); smp();
        total++; if ({gnt, a_ack, b_ack} !== {s, f[0], f[1]}) begin bad++; $display("FAIL rm_second got=%b/%b%b want=%b/%b%b", gnt, a_ack, b_ack, s, f[0], f[1]); end
        cyc(); if (f[1]) b_req = 1'b0; else a_req = 1'b0;
        smp();
        total++; if ({a_ack, b_ack} !== {s[0], s[1]}) begin bad++; $display("FAIL rm_second_ack got=%b%b want=%b%b", a_ack, b_ack, s[0], s[1]); end
        cyc(); a_req = 1'b0; b_req = 1'b0;
        cyc();
        $display("test_reset_mid done");
    endtask

    // Randomized traffic against a transaction model:
    // one winner per cycle, an ack one cycle later, and reads returning the last bytes written.
    task automatic test_random();
        bit busy[2], done[2], eack[2], rdp[2], we_v[2], el[2];
        logic [AW-1:0] ad[2];
        logic [DW-1:0] wd[2], erd[2], ekn[2];
        logic [MW-1:0] mk[2];
        logic [DW-1:0] mm_d [8];
        logic [MW-1:0] mm_k [8];
        bit last_b = 1'b0;
        logic [AW-1:0] h_addr = '0;
        logic [DW-1:0] h_wd = '0;
        logic [DW-1:0] rd;
        logic [1:0] eg;
        int w, s;
        int nacc = 0;
        for (int r = 0; r < 2; r++) begin busy[r] = 0; done[r] = 0; eack[r] = 0; rdp[r] = 0; end
        for (int i = 0; i < 8; i++) begin mm_d[i] = '0; mm_k[i] = '0; end
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (done[r]) busy[r] = 0;
                if (!busy[r] && $urandom_range(0, 1) == 0) begin
                    busy[r] = 1;
                    we_v[r] = ($urandom_range(0, 1) == 1);
                    ad[r] = 14'h100 + 14'($urandom_range(0, 7));
                    wd[r] = $urandom;
                    mk[r] = 4'($urandom_range(0, 15));
                end
            end
            a_req = busy[0]; a_we = we_v[0]; a_addr = ad[0]; a_wdata = wd[0]; a_wmsk = mk[0];
            b_req = busy[1]; b_we = we_v[1]; b_addr = ad[1]; b_wdata = wd[1]; b_wmsk = mk[1];
            smp();
            for (int r = 0; r < 2; r++) el[r] = busy[r] && !eack[r];
`ifdef SPRAM_ARB_RR_EN
            if (el[0] && el[1]) w = last_b ? 0 : 1;
`else
            if (el[0] && el[1]) w = 0;
`endif
            else if (el[0]) w = 0;
            else if (el[1]) w = 1;
            else w = -1;
            eg = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
            total++; if (gnt !== eg) begin bad++; $display("FAIL rnd_gnt c=%0d got=%b want=%b", c, gnt, eg); end
            total++; if (m_we !== ((w >= 0) ? we_v[w] : 1'b0)) begin bad++; $display("FAIL rnd_m_we c=%0d got=%b", c, m_we); end
            total++; if (m_wmsk !== ((w >= 0) ? mk[w] : 4'h0)) begin bad++; $display("FAIL rnd_m_wmsk c=%0d got=%h", c, m_wmsk); end
            total++; if ({m_addr, m_wdata} !== ((w >= 0) ? {ad[w], wd[w]} : {h_addr, h_wd})) begin bad++; $display("FAIL rnd_m_cmd c=%0d got=%h/%h", c, m_addr, m_wdata); end
            total++; if ({a_ack, b_ack} !== {eack[0], eack[1]}) begin bad++; $display("FAIL rnd_ack c=%0d got=%b%b want=%b%b", c, a_ack, b_ack, eack[0], eack[1]); end
            for (int r = 0; r < 2; r++) begin
                rd = (r == 0) ? a_rdata : b_rdata;
                if (eack[r] && rdp[r]) begin
                    total++; if ((rd & ekn[r]) !== (erd[r] & ekn[r])) begin bad++; $display("FAIL rnd_rdata c=%0d r=%0d got=%h want=%h mask=%h", c, r, rd, erd[r], ekn[r]); end
                end else if (!eack[r]) begin
                    total++; if (rd !== '0) begin bad++; $display("FAIL rnd_rdata_idle c=%0d r=%0d got=%h want=0", c, r, rd); end
                end
            end
            for (int r = 0; r < 2; r++) begin done[r] = eack[r]; eack[r] = (w == r); end
            if (w >= 0) begin
                nacc++;
                s = int'(ad[w][2:0]);
                rdp[w] = !we_v[w];
                if (we_v[w]) begin
                    for (int i = 0; i < MW; i++) if (mk[w][i]) begin mm_d[s][8*i +: 8] = wd[w][8*i +: 8]; mm_k[s][i] = 1'b1; end
                end else begin
                    erd[w] = mm_d[s];
                    for (int i = 0; i < MW; i++) ekn[w][8*i +: 8] = {8{mm_k[s][i]}};
                end
                h_addr = ad[w]; h_wd = wd[w]; last_b = (w == 1);
            end
            cyc();
        end
        a_req = 1'b0; b_req = 1'b0;
        cyc(); cyc();
        $display("test_random done accesses=%0d", nacc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_a_read();
        test_b_write();
        test_contention();
        test_alternate();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
